pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 212 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period/duty measurement: synchronizes pwm_in, times high and period in clk
// cycles, and computes duty percent with a 7-cycle restoring divider.
module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_in,
  output logic             valid,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             stuck,
  output logic             overrun
);

  localparam int DW = CNT_W + 7;
  localparam logic [CNT_W-1:0] AGE_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [DW-1:0]    HUNDRED = DW'(100);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, HIGH, LOW} state_t;

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       prime_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d, hstage_q, hstage_d, age_q, age_d;
  logic [CNT_W-1:0] pend_hi_q, pend_hi_d, pend_per_q, pend_per_d;
  logic [2:0]       div_step_q, div_step_d;
  logic [DW-1:0]    rem_q, rem_d, dsr_q, dsr_d;
  logic [6:0]       quo_q, quo_d;
  logic             valid_q, valid_d, stuck_q, stuck_d, overrun_q, overrun_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
  logic [6:0]       duty_q, duty_d;

  logic             rise, fall, busy, q_bit;
  logic [DW-1:0]    rem_sub;
  logic [CNT_W-1:0] per_inc, hi_inc;

  // prime_q[1] marks the first cycle s2 carries a real sample rather than its
  // reset value, so a line already high at release is not mistaken for low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      prime_q <= 2'b00;
    end else begin
      s1_q    <= pwm_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      prime_q <= {prime_q[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      per_q        <= '0;
      hi_q         <= '0;
      hstage_q     <= '0;
      age_q        <= '0;
      pend_hi_q    <= '0;
      pend_per_q   <= '0;
      div_step_q   <= '0;
      rem_q        <= '0;
      dsr_q        <= '0;
      quo_q        <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      overrun_q    <= 1'b0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      duty_q       <= '0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      hi_q         <= hi_d;
      hstage_q     <= hstage_d;
      age_q        <= age_d;
      pend_hi_q    <= pend_hi_d;
      pend_per_q   <= pend_per_d;
      div_step_q   <= div_step_d;
      rem_q        <= rem_d;
      dsr_q        <= dsr_d;
      quo_q        <= quo_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      overrun_q    <= overrun_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      duty_q       <= duty_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    hi_d         = hi_q;
    hstage_d     = hstage_q;
    age_d        = age_q;
    pend_hi_d    = pend_hi_q;
    pend_per_d   = pend_per_q;
    div_step_d   = div_step_q;
    rem_d        = rem_q;
    dsr_d        = dsr_q;
    quo_d        = quo_q;
    valid_d      = 1'b0;
    overrun_d    = 1'b0;
    stuck_d      = stuck_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    duty_d       = duty_q;

    rise    = s2_q & ~s3_q;
    fall    = ~s2_q & s3_q;
    busy    = (div_step_q != 3'd0);
    q_bit   = (rem_q >= dsr_q);
    rem_sub = rem_q - dsr_q;
    per_inc = (per_q == '1) ? per_q : per_q + 1'b1;
    hi_inc  = (hi_q == '1) ? hi_q : hi_q + 1'b1;

    // Divisor is pre-shifted by 6; quotient never exceeds 100 so 7 bits suffice.
    if (busy) begin
      quo_d      = {quo_q[5:0], q_bit};
      dsr_d      = dsr_q >> 1;
      div_step_d = div_step_q - 3'd1;
      if (q_bit) rem_d = rem_sub;
      if (div_step_q == 3'd1) begin
        valid_d      = 1'b1;
        stuck_d      = 1'b0;
        high_cnt_d   = pend_hi_q;
        period_cnt_d = pend_per_q;
        duty_d       = {quo_q[5:0], q_bit};
      end
    end

    unique case (state_q)
      IDLE: begin
        age_d = '0;
        if (prime_q[1] && !s2_q) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          state_d = HIGH;
          per_d   = CNT_W'(1);
          hi_d    = CNT_W'(1);
          age_d   = '0;
        end
      end
      HIGH: begin
        per_d = per_inc;
        hi_d  = hi_inc;
        if (fall) begin
          hstage_d = hi_q;
          state_d  = LOW;
          age_d    = '0;
        end else if (age_q == AGE_LIM) begin
          state_d      = IDLE;
          div_step_d   = 3'd0;
          stuck_d      = 1'b1;
          valid_d      = 1'b1;
          duty_d       = 7'd100;
          high_cnt_d   = '0;
          period_cnt_d = '0;
          age_d        = '0;
        end else begin
          age_d = age_q + 1'b1;
        end
      end
      LOW: begin
        per_d = per_inc;
        if (rise) begin
          if (busy) begin
            overrun_d = 1'b1;
          end else begin
            div_step_d = 3'd7;
            rem_d      = DW'(hstage_q) * HUNDRED;
            dsr_d      = {1'b0, per_q, 6'b0};
            quo_d      = '0;
            pend_hi_d  = hstage_q;
            pend_per_d = per_q;
          end
          per_d   = CNT_W'(1);
          hi_d    = CNT_W'(1);
          age_d   = '0;
          state_d = HIGH;
        end else if (age_q == AGE_LIM) begin
          state_d      = IDLE;
          div_step_d   = 3'd0;
          stuck_d      = 1'b1;
          valid_d      = 1'b1;
          duty_d       = 7'd0;
          high_cnt_d   = '0;
          period_cnt_d = '0;
          age_d        = '0;
        end else begin
          age_d = age_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign valid      = valid_q;
  assign high_cnt   = high_cnt_q;
  assign period_cnt = period_cnt_q;
  assign duty_pct   = duty_q;
  assign stuck      = stuck_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: steady waveforms, latency, timeouts,
// overrun on short periods, and reset behaviour.
module tb_pwm_capture;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             pwm_in = 1'b0;
  logic             valid, stuck, overrun;
  logic [CNT_W-1:0] high_cnt, period_cnt;
  logic [6:0]       duty_pct;

  int tests = 0;
  int fails = 0;
  int vcount = 0;
  int ocount = 0;
  int cyc = 0;
  int last_vcyc = 0;
  int prev_vcyc = 0;
  int vbase, obase;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .valid(valid),
    .high_cnt(high_cnt), .period_cnt(period_cnt), .duty_pct(duty_pct),
    .stuck(stuck), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vcount    <= vcount + 1;
      prev_vcyc <= last_vcyc;
      last_vcyc <= cyc;
      $display("[TB] valid cyc=%0d high=%0d period=%0d duty=%0d stuck=%0d",
               cyc, high_cnt, period_cnt, duty_pct, stuck);
    end
    if (overrun) begin
      ocount <= ocount + 1;
      $display("[TB] overrun cyc=%0d", cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_outs(input string tag, input int h, input int p, input int d, input int s);
    chk({tag, "_high"}, 32'(high_cnt), 32'(h));
    chk({tag, "_period"}, 32'(period_cnt), 32'(p));
    chk({tag, "_duty"}, 32'(duty_pct), 32'(d));
    chk({tag, "_stuck"}, 32'(stuck), 32'(s));
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk_outs("rst", 0, 0, 0, 0);
    rst_n = 1'b1;

    // 50 high / 50 low, with exact latency from rise to valid
    drive(1'b0, 5);
    drive(1'b1, 50);
    drive(1'b0, 50);
    chk("first_period_silent", 32'(vcount), 32'd0);
    pwm_in = 1'b1;
    repeat (9) @(negedge clk);
    chk("lat_early", 32'(valid), 32'd0);
    @(negedge clk);
    chk("lat_valid", 32'(valid), 32'd1);
    chk_outs("p50", 50, 100, 50, 0);

    // held high past the timeout
    drive(1'b1, 250);
    chk("to_hi_vcount", 32'(vcount), 32'd2);
    chk_outs("to_hi", 0, 0, 100, 1);

    // held low past the timeout, valid timed exactly from the fall
    drive(1'b0, 5);
    drive(1'b1, 4);
    pwm_in = 1'b0;
    repeat (2 + TIMEOUT) @(negedge clk);
    chk("to_lo_early", 32'(valid), 32'd0);
    @(negedge clk);
    chk("to_lo_valid", 32'(valid), 32'd1);
    chk_outs("to_lo", 0, 0, 0, 1);

    // resume 4/21: stuck clears on the next measurement
    drive(1'b0, 5);
    chk("stuck_held", 32'(stuck), 32'd1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4);
      drive(1'b0, 17);
    end
    chk("p21_vcount", 32'(vcount), 32'd6);
    chk_outs("p21", 4, 21, 19, 0);
    chk("p21_interval", 32'(last_vcyc - prev_vcyc), 32'd21);
    chk("p21_no_overrun", 32'(ocount), 32'd0);

    // period 5: every other measurement dropped while the divider is busy
    vbase = vcount;
    obase = ocount;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2);
      drive(1'b0, 3);
    end
    drive(1'b0, 20);
    chk("p5_overruns", 32'(ocount - obase), 32'd5);
    chk("p5_valids", 32'(vcount - vbase), 32'd5);
    chk_outs("p5", 2, 5, 40, 0);

    // reset mid-divide, released with the input high
    drive(1'b1, 2);
    drive(1'b0, 20);
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk_outs("mid_rst", 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vbase = vcount;
    drive(1'b1, 10);
    drive(1'b0, 5);
    drive(1'b1, 4);
    drive(1'b0, 17);
    chk("post_rst_silent", 32'(vcount - vbase), 32'd0);
    drive(1'b1, 4);
    drive(1'b0, 17);
    chk("post_rst_vcount", 32'(vcount - vbase), 32'd1);
    chk_outs("post_rst", 4, 21, 19, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
